// File: rtl/ddfs_pkg.sv
// Shared DDFS definitions: frequency-word width, sweep modes and sweep FSM states.
// Mode decoding depends on the optional SWEEP_TRIANGLE_EN macro.
package ddfs_pkg;

    localparam int DDFS_FW = 23;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2
    } sweep_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    // Reserved encoding 11 runs as a single sweep; 10 falls back to sawtooth without triangle support.
    function automatic sweep_mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return SAW;
`ifdef SWEEP_TRIANGLE_EN
            2'b10:   return TRI;
`else
            2'b10:   return SAW;
`endif
            default: return SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/ddfs_step_unit.sv
// Combinational next-frequency computation with endpoint clamping for the sweep controller.
// Down-stepping and the start-side flag exist only when SWEEP_TRIANGLE_EN is defined.
module ddfs_step_unit #(
    parameter int FW = 23
) (
    input  logic [FW-1:0] f,
    input  logic [FW-1:0] step,
    input  logic [FW-1:0] stop,
`ifdef SWEEP_TRIANGLE_EN
    input  logic [FW-1:0] start,
    input  logic          down,
    output logic          at_start,
`endif
    output logic [FW-1:0] next_f,
    output logic          at_stop
);

    logic [FW-1:0] step_eff;
    logic [FW:0]   sum;
    logic [FW-1:0] up_f;

    // A zero step would stall the sweep forever, so it advances by one instead.
    assign step_eff = (step == '0) ? {{(FW-1){1'b0}}, 1'b1} : step;
    assign sum      = {1'b0, f} + {1'b0, step_eff};
    assign up_f     = (sum[FW] || (sum[FW-1:0] > stop)) ? stop : sum[FW-1:0];
    assign at_stop  = (f >= stop);

`ifdef SWEEP_TRIANGLE_EN
    logic [FW:0] diff;

    assign diff     = {1'b0, f} - {1'b0, step_eff};
    assign at_start = (f <= start);

    always_comb begin
        // NOTE: assigning a default first guarantees every path drives next_f, so no latch is inferred.
        next_f = up_f;
        if (down) begin
            next_f = (diff[FW] || (diff[FW-1:0] < start)) ? start : diff[FW-1:0];
        end
    end
`else
    assign next_f = up_f;
`endif

endmodule

// File: rtl/ddfs_sweep_ctrl.sv
// Linear frequency-sweep scheduler driving the ddfs phase increment (single, sawtooth, triangle).
// Triangle mode and the direction register are built only when SWEEP_TRIANGLE_EN is defined.
module ddfs_sweep_ctrl
    import ddfs_pkg::*;
#(
    parameter int FW = DDFS_FW,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [FW-1:0] cfg_start_f,
    input  logic [FW-1:0] cfg_stop_f,
    input  logic [FW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic          go,
    input  logic          abort,
    output logic [FW-1:0] fcontrol,
    output logic          busy,
    output logic          done,
    output logic          wrap
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]    state;
    logic [FW-1:0] f_q;
    logic [FW-1:0] start_q;
    logic [FW-1:0] stop_q;
    logic [FW-1:0] step_q;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] cnt_q;
    sweep_mode_t   mode_q;
    logic          wrap_q;
    logic          take_cfg;
    logic [FW-1:0] next_f;
    logic          at_stop;

    assign take_cfg = cfg_valid && (state == S_IDLE);

`ifdef SWEEP_TRIANGLE_EN
    logic down_q;
    logic at_start;
    logic step_down;

    // Direction fed to the step unit already reflects a turn taken on this reload.
    assign step_down = down_q ? !at_start : (at_stop && (mode_q == TRI));
`endif

    ddfs_step_unit #(.FW(FW)) u_step (
        .f        (f_q),
        .step     (step_q),
        .stop     (stop_q),
`ifdef SWEEP_TRIANGLE_EN
        .start    (start_q),
        .down     (step_down),
        .at_start (at_start),
`endif
        .next_f   (next_f),
        .at_stop  (at_stop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            f_q     <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            mode_q  <= SINGLE;
            wrap_q  <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
            down_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            wrap_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take_cfg) begin
                        start_q <= cfg_start_f;
                        stop_q  <= cfg_stop_f;
                        step_q  <= cfg_step;
                        dwell_q <= cfg_dwell;
                        mode_q  <= decode_mode(cfg_mode);
                    end
                    if (go && !abort) begin
                        state <= S_RUN;
                        f_q   <= take_cfg ? cfg_start_f : start_q;
                        cnt_q <= take_cfg ? cfg_dwell : dwell_q;
`ifdef SWEEP_TRIANGLE_EN
                        down_q <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DW'(1);
                    end else begin
                        cnt_q <= dwell_q;
`ifdef SWEEP_TRIANGLE_EN
                        if (down_q) begin
                            f_q <= next_f;
                            if (at_start) begin
                                down_q <= 1'b0;
                                wrap_q <= 1'b1;
                            end
                        end else
`endif
                        if (at_stop) begin
                            case (mode_q)
                                SINGLE: state <= S_DONE;
`ifdef SWEEP_TRIANGLE_EN
                                // A flat sweep (start >= stop) has nowhere to turn, so it just repeats.
                                TRI: begin
                                    if (at_start) begin
                                        f_q    <= start_q;
                                        wrap_q <= 1'b1;
                                    end else begin
                                        f_q    <= next_f;
                                        down_q <= 1'b1;
                                    end
                                end
`endif
                                default: begin
                                    f_q    <= start_q;
                                    wrap_q <= 1'b1;
                                end
                            endcase
                        end else begin
                            f_q <= next_f;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fcontrol  = f_q;
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign cfg_ready = (state == S_IDLE);
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Directed bench for ddfs_sweep_ctrl; expected sequences are hand-computed.
// Mode 10 expectations follow SWEEP_TRIANGLE_EN when it is defined.
module tb_ddfs_sweep_ctrl;

    localparam int FW = 23;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [FW-1:0] cfg_start_f;
    logic [FW-1:0] cfg_stop_f;
    logic [FW-1:0] cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic          go;
    logic          abort;
    logic [FW-1:0] fcontrol;
    logic          busy;
    logic          done;
    logic          wrap;

    int checks   = 0;
    int failures = 0;

    logic [FW-1:0] exp_f[$];
    logic          exp_w[$];

    always #5 clk = ~clk;

    ddfs_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_start_f (cfg_start_f),
        .cfg_stop_f  (cfg_stop_f),
        .cfg_step    (cfg_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .go          (go),
        .abort       (abort),
        .fcontrol    (fcontrol),
        .busy        (busy),
        .done        (done),
        .wrap        (wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [FW-1:0] v, input logic w, input int hold);
        for (int i = 0; i < hold; i++) begin
            exp_f.push_back(v);
            exp_w.push_back(w && (i == 0));
        end
    endtask

    task automatic configure(input logic [FW-1:0] s, input logic [FW-1:0] e,
                             input logic [FW-1:0] st, input logic [DW-1:0] d,
                             input logic [1:0] m, input logic with_go);
        cfg_start_f = s;
        cfg_stop_f  = e;
        cfg_step    = st;
        cfg_dwell   = d;
        cfg_mode    = m;
        cfg_valid   = 1'b1;
        go          = with_go;
        tick();
        cfg_valid = 1'b0;
        go        = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // Walks the expected per-cycle queue; at index poke it offers go and a bogus config mid-run.
    task automatic drain(input string tag, input int poke);
        for (int i = 0; i < exp_f.size(); i++) begin
            if (i > 0) begin
                tick();
                go        = 1'b0;
                cfg_valid = 1'b0;
            end
            check({tag, ".f"}, 32'(fcontrol), 32'(exp_f[i]));
            check({tag, ".wrap"}, 32'(wrap), 32'(exp_w[i]));
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".done"}, 32'(done), 32'd0);
            if (i == poke) begin
                check({tag, ".ready_run"}, 32'(cfg_ready), 32'd0);
                go          = 1'b1;
                cfg_valid   = 1'b1;
                cfg_start_f = 23'd7;
                cfg_stop_f  = 23'd9;
            end
        end
        exp_f.delete();
        exp_w.delete();
    endtask

    task automatic expect_done(input string tag, input logic [FW-1:0] f_end);
        tick();
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
        check({tag, ".f_done"}, 32'(fcontrol), 32'(f_end));
        check({tag, ".ready_done"}, 32'(cfg_ready), 32'd0);
        tick();
        check({tag, ".done_clr"}, 32'(done), 32'd0);
        check({tag, ".ready_back"}, 32'(cfg_ready), 32'd1);
        check({tag, ".f_idle"}, 32'(fcontrol), 32'(f_end));
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; go = 1'b0; abort = 1'b0;
        cfg_start_f = '0; cfg_stop_f = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
        tick();
        tick();
        check("rst.f", 32'(fcontrol), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.wrap", 32'(wrap), 32'd0);
        check("rst.ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Single sweep, config and go together, dwell 2; go/config mid-run ignored.
        push(23'd100, 1'b0, 3); push(23'd110, 1'b0, 3);
        push(23'd120, 1'b0, 3); push(23'd130, 1'b0, 3);
        configure(23'd100, 23'd130, 23'd10, 16'd2, 2'b00, 1'b1);
        drain("single", 4);
        expect_done("single", 23'd130);

        // Overshoot clamp; config first, go later; shadow survives ignored mid-run config.
        configure(23'd100, 23'd125, 23'd10, 16'd0, 2'b00, 1'b0);
        check("cfg_only.busy", 32'(busy), 32'd0);
        check("cfg_only.f_hold", 32'(fcontrol), 32'd130);
        pulse_go();
        push(23'd100, 1'b0, 1); push(23'd110, 1'b0, 1);
        push(23'd120, 1'b0, 1); push(23'd125, 1'b0, 1);
        drain("over", 1);
        expect_done("over", 23'd125);
        pulse_go();
        push(23'd100, 1'b0, 1); push(23'd110, 1'b0, 1);
        push(23'd120, 1'b0, 1); push(23'd125, 1'b0, 1);
        drain("reuse", -1);
        expect_done("reuse", 23'd125);

        // Near full scale: the carry clamps to stop instead of wrapping through zero.
        push(23'h7FFFF0, 1'b0, 1); push(23'h7FFFFF, 1'b0, 1);
        configure(23'h7FFFF0, 23'h7FFFFF, 23'h20, 16'd0, 2'b00, 1'b1);
        drain("full", -1);
        expect_done("full", 23'h7FFFFF);

        // Zero step advances by one; reserved mode 11 runs as single.
        push(23'd10, 1'b0, 1); push(23'd11, 1'b0, 1); push(23'd12, 1'b0, 1);
        configure(23'd10, 23'd12, 23'd0, 16'd0, 2'b11, 1'b1);
        drain("step0", -1);
        expect_done("step0", 23'd12);

        // start > stop: constant tone for one dwell, then done.
        push(23'd50, 1'b0, 2);
        configure(23'd50, 23'd40, 23'd5, 16'd1, 2'b00, 1'b1);
        drain("flat", -1);
        expect_done("flat", 23'd50);

        // Sawtooth, then abort while at 120.
        push(23'd100, 1'b0, 1); push(23'd110, 1'b0, 1); push(23'd120, 1'b0, 1); push(23'd130, 1'b0, 1);
        push(23'd100, 1'b1, 1); push(23'd110, 1'b0, 1); push(23'd120, 1'b0, 1); push(23'd130, 1'b0, 1);
        push(23'd100, 1'b1, 1); push(23'd110, 1'b0, 1); push(23'd120, 1'b0, 1);
        configure(23'd100, 23'd130, 23'd10, 16'd0, 2'b01, 1'b1);
        drain("saw", -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.f", 32'(fcontrol), 32'd120);
        check("abort.ready", 32'(cfg_ready), 32'd1);
        tick();
        check("abort.done2", 32'(done), 32'd0);
        check("abort.f2", 32'(fcontrol), 32'd120);

        // go and abort together in IDLE: stays idle.
        go = 1'b1;
        abort = 1'b1;
        tick();
        go = 1'b0;
        abort = 1'b0;
        check("goabort.busy", 32'(busy), 32'd0);
        check("goabort.ready", 32'(cfg_ready), 32'd1);
        check("goabort.f", 32'(fcontrol), 32'd120);

        // Mode 10: triangle when enabled, otherwise sawtooth.
        push(23'd100, 1'b0, 1); push(23'd110, 1'b0, 1); push(23'd120, 1'b0, 1); push(23'd130, 1'b0, 1);
`ifdef SWEEP_TRIANGLE_EN
        push(23'd120, 1'b0, 1); push(23'd110, 1'b0, 1); push(23'd100, 1'b0, 1);
        push(23'd110, 1'b1, 1); push(23'd120, 1'b0, 1); push(23'd130, 1'b0, 1);
        push(23'd120, 1'b0, 1);
`else
        push(23'd100, 1'b1, 1); push(23'd110, 1'b0, 1); push(23'd120, 1'b0, 1);
        push(23'd130, 1'b0, 1); push(23'd100, 1'b1, 1); push(23'd110, 1'b0, 1);
        push(23'd120, 1'b0, 1);
`endif
        configure(23'd100, 23'd130, 23'd10, 16'd0, 2'b10, 1'b1);
        drain("tri", -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("tri_abort.busy", 32'(busy), 32'd0);
        check("tri_abort.f", 32'(fcontrol), 32'd120);

        // Flat sawtooth pulses wrap every dwell; then reset mid-run.
        push(23'd50, 1'b0, 2); push(23'd50, 1'b1, 2); push(23'd50, 1'b1, 2);
        configure(23'd50, 23'd50, 23'd3, 16'd1, 2'b01, 1'b1);
        drain("flat_saw", -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.f", 32'(fcontrol), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.wrap", 32'(wrap), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.ready", 32'(cfg_ready), 32'd1);

        // Shadow registers were cleared: go alone runs 0..0 single and finishes.
        pulse_go();
        push(23'd0, 1'b0, 1);
        drain("zero_cfg", -1);
        expect_done("zero_cfg", 23'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
